random_pulse_sched: RTL



---
 rtl/random_pulse_sched_pkg.sv | 35 +++
 rtl/random_pulse_sched_if.sv | 37 +++
 rtl/random_pulse_sched_lfsr32.sv | 33 +++
 rtl/random_pulse_sched.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/random_pulse_sched_pkg.sv
// Shared types, constants and the spacing scaler for the random pulse scheduler.
// Latency: n/a (types and a pure combinational function only).
// Backpressure: n/a.
package random_pulse_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } t_rps_state;

   // Galois taps for x^32+x^22+x^2+x+1, right-shifting form: bit i is x^(i+1),
   // and the x^0 term is the bit that feeds back out of bit 0.
   localparam logic [31:0] c_lfsr_poly = 32'h80200003;

   // Uniform scaling of a frac_bits-wide random fraction r onto [min_v, max_v]:
   //    min_v + floor(r * (max_v - min_v + 1) / 2^frac_bits)
   // Works on 32-bit operands with a 65-bit product, so every caller width up to
   // 32 bits fits. Because r < 2^frac_bits, the result never exceeds max_v.
   // The caller must pass r already masked to frac_bits bits.
   function automatic logic [31:0] f_scale_spacing(
      input logic [31:0] r,
      input logic [31:0] min_v,
      input logic [31:0] max_v,
      input int unsigned frac_bits
   );
      logic [64:0] span;
      logic [64:0] prod;
      span = 65'(max_v) - 65'(min_v) + 65'd1;
      prod = 65'(r) * span;
      prod = prod >> frac_bits;
      return min_v + prod[31:0];
   endfunction

endpackage

// File: rtl/random_pulse_sched_if.sv
// Control/status bundle between a host and the random pulse scheduler.
// Latency: n/a (wires only).
// Backpressure: none; start/stop are level requests sampled every cycle.
// Ports: config (width/min/max spacing/count), seed load, start/stop requests in;
//        pulse, busy, done strobe, pulse index and config-error strobe out.
interface random_pulse_sched_if #(
   parameter int g_width_bits = 16,
   parameter int g_count_bits = 16
) ();
   logic                    start_i;
   logic                    stop_i;
   logic [g_width_bits-1:0] width_i;
   logic [g_width_bits-1:0] min_spacing_i;
   logic [g_width_bits-1:0] max_spacing_i;
   logic [g_count_bits-1:0] count_i;
   logic                    seed_load_i;
   logic [31:0]             seed_i;
   logic                    pulse_o;
   logic                    busy_o;
   logic                    done_o;
   logic [g_count_bits-1:0] pulse_idx_o;
   logic                    cfg_err_o;

   // Host side: drives requests and configuration, observes status.
   modport master (
      output start_i, stop_i, width_i, min_spacing_i, max_spacing_i, count_i,
             seed_load_i, seed_i,
      input  pulse_o, busy_o, done_o, pulse_idx_o, cfg_err_o
   );

   // Scheduler side.
   modport slave (
      input  start_i, stop_i, width_i, min_spacing_i, max_spacing_i, count_i,
             seed_load_i, seed_i,
      output pulse_o, busy_o, done_o, pulse_idx_o, cfg_err_o
   );
endinterface

// File: rtl/random_pulse_sched_lfsr32.sv
// 32-bit Galois LFSR with synchronous seed load; a zero seed becomes g_lfsr_seed.
// Latency: load/advance take effect on the next clock edge.
// Backpressure: none; load has priority over advance.
// Ports: clk_sys_i, rst_n_i, load_i + seed_i, advance_i in; state_o (32 bits) out.
module rps_lfsr32
   import random_pulse_pkg::*;
#(
   parameter logic [31:0] g_lfsr_seed = 32'h1
) (
   input  logic        clk_sys_i,
   input  logic        rst_n_i,
   input  logic        load_i,
   input  logic [31:0] seed_i,
   input  logic        advance_i,
   output logic [31:0] state_o
);

   logic [31:0] lfsr_q;

   always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         lfsr_q <= g_lfsr_seed;
      end else if (load_i) begin
         // An all-zero state would lock the register up forever.
         lfsr_q <= (seed_i == 32'h0) ? g_lfsr_seed : seed_i;
      end else if (advance_i) begin
         lfsr_q <= {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? c_lfsr_poly : 32'h0);
      end
   end

   assign state_o = lfsr_q;

endmodule

// File: rtl/random_pulse_sched.sv
// Pulse-train scheduler: fixed-width pulses separated by LFSR-drawn spacing in [min, max].
// Latency: start sampled at edge N gives pulse_o=1 after edge N; all outputs registered.
// Backpressure: none; start ignored while busy, stop honoured at pulse end (HIGH) or next edge (LOW).
// Ports: clk_sys_i, rst_n_i (async, active-low); bus = slave side of random_pulse_sched_if.
module random_pulse_sched
   import random_pulse_pkg::*;
#(
   parameter int          g_width_bits = 16,
   parameter int          g_count_bits = 16,
   parameter logic [31:0] g_lfsr_seed  = 32'h1
) (
   input  logic                 clk_sys_i,
   input  logic                 rst_n_i,
   random_pulse_sched_if.slave  bus
);

   localparam logic [g_width_bits-1:0] c_w_one   = 1;
   localparam logic [g_count_bits-1:0] c_idx_one = 1;

   t_rps_state              state_q;
   logic [g_width_bits-1:0] width_q;
   logic [g_width_bits-1:0] min_q;
   logic [g_width_bits-1:0] max_q;
   logic [g_count_bits-1:0] count_q;
   logic [g_width_bits-1:0] cnt_q;       // cycles left in the current HIGH/LOW phase, minus one
   logic                    stop_pend_q; // stop seen mid-pulse, honoured when the pulse ends
   logic                    pulse_q;
   logic                    busy_q;
   logic                    done_q;
   logic                    cfg_err_q;
   logic [g_count_bits-1:0] idx_q;

   logic [31:0]             lfsr_state;
   logic                    lfsr_load;
   logic                    lfsr_adv;
   logic                    unused_lfsr;
   logic                    cfg_ok;
   logic                    high_last;
   logic                    train_end;
   logic [g_count_bits-1:0] idx_next;
   logic [g_width_bits-1:0] spacing;

   // Seed loads only while idle, so a start in the same cycle sees the new seed
   // by the time the first spacing is drawn (at the end of the first pulse).
   assign lfsr_load = (state_q == IDLE) && bus.seed_load_i;

   // One draw per HIGH exit, including the exit that ends the train, so the
   // random sequence depends only on how many pulses have been emitted.
   assign high_last = (state_q == HIGH) && (cnt_q == '0);
   assign lfsr_adv  = high_last;

   rps_lfsr32 #(
      .g_lfsr_seed (g_lfsr_seed)
   ) u_lfsr (
      .clk_sys_i (clk_sys_i),
      .rst_n_i   (rst_n_i),
      .load_i    (lfsr_load),
      .seed_i    (bus.seed_i),
      .advance_i (lfsr_adv),
      .state_o   (lfsr_state)
   );

   // Only the low g_width_bits of the LFSR feed the draw.
   assign unused_lfsr = ^lfsr_state;

   assign cfg_ok = (bus.width_i != '0) && (bus.min_spacing_i != '0) &&
                   (bus.min_spacing_i <= bus.max_spacing_i);

   assign idx_next  = idx_q + c_idx_one;
   assign train_end = ((count_q != '0) && (idx_next == count_q)) ||
                      stop_pend_q || bus.stop_i;

   assign spacing = g_width_bits'(f_scale_spacing(32'(lfsr_state[g_width_bits-1:0]),
                                                  32'(min_q), 32'(max_q),
                                                  g_width_bits));

   always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= IDLE;
         width_q     <= '0;
         min_q       <= '0;
         max_q       <= '0;
         count_q     <= '0;
         cnt_q       <= '0;
         stop_pend_q <= 1'b0;
         pulse_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cfg_err_q   <= 1'b0;
         idx_q       <= '0;
      end else begin
         done_q    <= 1'b0;
         cfg_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // Start beats a simultaneous stop; a stop alone does nothing here.
               if (bus.start_i) begin
                  if (cfg_ok) begin
                     width_q     <= bus.width_i;
                     min_q       <= bus.min_spacing_i;
                     max_q       <= bus.max_spacing_i;
                     count_q     <= bus.count_i;
                     cnt_q       <= bus.width_i - c_w_one;
                     idx_q       <= '0;
                     stop_pend_q <= 1'b0;
                     pulse_q     <= 1'b1;
                     busy_q      <= 1'b1;
                     state_q     <= HIGH;
                  end else begin
                     cfg_err_q <= 1'b1;
                  end
               end
            end

            HIGH: begin
               if (bus.stop_i) begin
                  stop_pend_q <= 1'b1;
               end
               if (cnt_q == '0) begin
                  idx_q   <= idx_next;
                  pulse_q <= 1'b0;
                  if (train_end) begin
                     busy_q      <= 1'b0;
                     done_q      <= 1'b1;
                     stop_pend_q <= 1'b0;
                     state_q     <= IDLE;
                  end else begin
                     cnt_q   <= spacing - c_w_one;
                     state_q <= LOW;
                  end
               end else begin
                  cnt_q <= cnt_q - c_w_one;
               end
            end

            LOW: begin
               if (bus.stop_i) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end else if (cnt_q == '0) begin
                  pulse_q <= 1'b1;
                  cnt_q   <= width_q - c_w_one;
                  state_q <= HIGH;
               end else begin
                  cnt_q <= cnt_q - c_w_one;
               end
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.pulse_o     = pulse_q;
   assign bus.busy_o      = busy_q;
   assign bus.done_o      = done_q;
   assign bus.pulse_idx_o = idx_q;
   assign bus.cfg_err_o   = cfg_err_q;

endmodule
